// File: rtl/any1_issue_ctrl.sv
// -----------------------------------------------------------------------------
// any1_issue_ctrl
//
// Single-entry issue stage. It holds one decoded instruction, waits until none
// of its operands or its target is still being written, reads its operands from
// the register file (using a second cycle for Rc if needed), and then offers it
// to the execute stage. A 64-entry scoreboard ("busy" vector) tracks which
// registers have results in flight.
//
// State sequence: EMPTY -> HAZ -> (RDC) -> OUT -> EMPTY/HAZ
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   dec_valid_i / dec_ready_o         decode handshake
//   dec_ra_i..dec_rt_i                register specifiers (6 bits each)
//   dec_rfwr_i, dec_needrc_i          writes Rt / needs third operand Rc
//   dec_ui_i, dec_ip_i                unimplemented flag / instruction address
//   rf_ra_o, rf_rb_o                  register-file read addresses
//   iss_valid_o / iss_ready_i         execute handshake
//   iss_ip_o, iss_rt_o                address and target of held instruction
//   wb_valid_i, wb_rt_i               writeback, clears the target's busy bit
//   flush_i                           drop the held instruction
//   uiexc_o, uiexc_ip_o               one-cycle unimplemented-instruction pulse
//   stall_cnt_o                       saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module any1_issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [5:0]  dec_ra_i,
  input  logic [5:0]  dec_rb_i,
  input  logic [5:0]  dec_rc_i,
  input  logic [5:0]  dec_rt_i,
  input  logic        dec_rfwr_i,
  input  logic        dec_needrc_i,
  input  logic        dec_ui_i,
  input  logic [31:0] dec_ip_i,
  output logic [5:0]  rf_ra_o,
  output logic [5:0]  rf_rb_o,
  output logic        iss_valid_o,
  input  logic        iss_ready_i,
  output logic [31:0] iss_ip_o,
  output logic [5:0]  iss_rt_o,
  input  logic        wb_valid_i,
  input  logic [5:0]  wb_rt_i,
  input  logic        flush_i,
  output logic        uiexc_o,
  output logic [31:0] uiexc_ip_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HAZ   = 2'd1,
    S_RDC   = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e      state_q;

  // Hold register
  logic [5:0]  ra_q, rb_q, rc_q, rt_q;
  logic        rfwr_q, needrc_q, ui_q;
  logic [31:0] ip_q;

  logic [63:0] busy_q, busy_d;
  logic [15:0] stall_cnt_q;

  logic        hazard;
  logic        accept;
  logic        issue;

  // Hazard looks only at the registered scoreboard, so a writeback is seen
  // one cycle after it happens.
  assign hazard = busy_q[ra_q] | busy_q[rb_q] | (needrc_q & busy_q[rc_q]) |
                  (rfwr_q & busy_q[rt_q]);

  assign iss_valid_o = (state_q == S_OUT);
  assign issue       = iss_valid_o & iss_ready_i;
  assign dec_ready_o = ~flush_i & ((state_q == S_EMPTY) | issue);
  assign accept      = dec_valid_i & dec_ready_o;

  assign uiexc_o     = (state_q == S_HAZ) & ui_q & ~flush_i;
  assign uiexc_ip_o  = ip_q;
  assign iss_ip_o    = ip_q;
  assign iss_rt_o    = rt_q;
  assign stall_cnt_o = stall_cnt_q;

  // Scoreboard next state: clear on writeback, then set on issue so that a
  // simultaneous set and clear of the same register leaves it busy. R0 is
  // hard-wired to never be busy.
  always_comb begin
    // NOTE: assign every always_comb output a default first; a path that
    // leaves it unassigned would infer a latch.
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_rt_i] = 1'b0;
    if (issue && rfwr_q) busy_d[rt_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Register-file read ports: Ra/Rb during HAZ, Rc/Rb during RDC.
  always_comb begin
    rf_ra_o = 6'd0;
    rf_rb_o = 6'd0;
    case (state_q)
      S_HAZ: begin
        rf_ra_o = ra_q;
        rf_rb_o = rb_q;
      end
      S_RDC: begin
        rf_ra_o = rc_q;
        rf_rb_o = rb_q;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the scoreboard is control state, not storage, so it is reset
      // along with everything else; no busy bit may survive a reset.
      state_q     <= S_EMPTY;
      ra_q        <= 6'd0;
      rb_q        <= 6'd0;
      rc_q        <= 6'd0;
      rt_q        <= 6'd0;
      rfwr_q      <= 1'b0;
      needrc_q    <= 1'b0;
      ui_q        <= 1'b0;
      ip_q        <= 32'd0;
      busy_q      <= 64'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      busy_q <= busy_d;

      if (accept) begin
        ra_q     <= dec_ra_i;
        rb_q     <= dec_rb_i;
        rc_q     <= dec_rc_i;
        rt_q     <= dec_rt_i;
        rfwr_q   <= dec_rfwr_i;
        needrc_q <= dec_needrc_i;
        ui_q     <= dec_ui_i;
        ip_q     <= dec_ip_i;
      end

      if (flush_i) begin
        state_q <= S_EMPTY;
      end else begin
        case (state_q)
          S_EMPTY: if (accept) state_q <= S_HAZ;
          S_HAZ: begin
            // Unimplemented instructions are discarded before any hazard check.
            if (ui_q) begin
              state_q <= S_EMPTY;
            end else if (hazard) begin
              if (stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            end else begin
              state_q <= needrc_q ? S_RDC : S_OUT;
            end
          end
          S_RDC: state_q <= S_OUT;
          S_OUT: if (issue) state_q <= accept ? S_HAZ : S_EMPTY;
          default: state_q <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_any1_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_any1_issue_ctrl
//
// Directed bench for any1_issue_ctrl. A per-cycle vector table walks through
// a plain ALU issue, a RAW stall released by writeback, a three-operand store,
// an unimplemented instruction, an R0 writer/reader pair and a flush in OUT.
// Hand-written sequences then cover flush during an OUT handshake combined with
// a same-register writeback, stall-counter saturation and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_any1_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [5:0]  dec_ra_i, dec_rb_i, dec_rc_i, dec_rt_i;
  logic        dec_rfwr_i, dec_needrc_i, dec_ui_i;
  logic [31:0] dec_ip_i;
  logic [5:0]  rf_ra_o, rf_rb_o;
  logic        iss_valid_o;
  logic        iss_ready_i;
  logic [31:0] iss_ip_o;
  logic [5:0]  iss_rt_o;
  logic        wb_valid_i;
  logic [5:0]  wb_rt_i;
  logic        flush_i;
  logic        uiexc_o;
  logic [31:0] uiexc_ip_o;
  logic [15:0] stall_cnt_o;

  any1_issue_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dec_valid_i  (dec_valid_i),
    .dec_ready_o  (dec_ready_o),
    .dec_ra_i     (dec_ra_i),
    .dec_rb_i     (dec_rb_i),
    .dec_rc_i     (dec_rc_i),
    .dec_rt_i     (dec_rt_i),
    .dec_rfwr_i   (dec_rfwr_i),
    .dec_needrc_i (dec_needrc_i),
    .dec_ui_i     (dec_ui_i),
    .dec_ip_i     (dec_ip_i),
    .rf_ra_o      (rf_ra_o),
    .rf_rb_o      (rf_rb_o),
    .iss_valid_o  (iss_valid_o),
    .iss_ready_i  (iss_ready_i),
    .iss_ip_o     (iss_ip_o),
    .iss_rt_o     (iss_rt_o),
    .wb_valid_i   (wb_valid_i),
    .wb_rt_i      (wb_rt_i),
    .flush_i      (flush_i),
    .uiexc_o      (uiexc_o),
    .uiexc_ip_o   (uiexc_ip_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    // inputs applied for one cycle
    logic        dv;
    logic [5:0]  ra, rb, rc, rt;
    logic        rfwr, nrc, ui;
    logic [31:0] ip;
    logic        irdy, wbv;
    logic [5:0]  wbrt;
    logic        fl;
    // outputs expected during that cycle
    logic        e_rdy;
    logic [5:0]  e_ra, e_rb;
    logic        e_iv;
    logic [5:0]  e_rt;
    logic [31:0] e_ip;
    logic        e_ui;
    logic [31:0] e_uiip;
    logic [15:0] e_stall;
    // one scoreboard bit expected during that cycle
    logic [5:0]  bit_idx;
    logic        e_bit;
  } vec_t;

  localparam int NVEC = 22;
  vec_t tbl [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic dv, input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] rc,
    input logic [5:0] rt, input logic rfwr, input logic nrc, input logic ui,
    input logic [31:0] ip, input logic irdy, input logic wbv, input logic [5:0] wbrt,
    input logic fl, input logic e_rdy, input logic [5:0] e_ra, input logic [5:0] e_rb,
    input logic e_iv, input logic [5:0] e_rt, input logic [31:0] e_ip, input logic e_ui,
    input logic [31:0] e_uiip, input logic [15:0] e_stall, input logic [5:0] bit_idx,
    input logic e_bit);
    vec_t v;
    v.dv = dv; v.ra = ra; v.rb = rb; v.rc = rc; v.rt = rt;
    v.rfwr = rfwr; v.nrc = nrc; v.ui = ui; v.ip = ip;
    v.irdy = irdy; v.wbv = wbv; v.wbrt = wbrt; v.fl = fl;
    v.e_rdy = e_rdy; v.e_ra = e_ra; v.e_rb = e_rb; v.e_iv = e_iv;
    v.e_rt = e_rt; v.e_ip = e_ip; v.e_ui = e_ui; v.e_uiip = e_uiip;
    v.e_stall = e_stall; v.bit_idx = bit_idx; v.e_bit = e_bit;
    return v;
  endfunction

  task automatic idle_inputs();
    dec_valid_i = 0; dec_ra_i = 0; dec_rb_i = 0; dec_rc_i = 0; dec_rt_i = 0;
    dec_rfwr_i = 0; dec_needrc_i = 0; dec_ui_i = 0; dec_ip_i = 0;
    iss_ready_i = 0; wb_valid_i = 0; wb_rt_i = 0; flush_i = 0;
  endtask

  task automatic offer(input logic [5:0] ra, input logic [5:0] rb, input logic [5:0] rt,
                       input logic rfwr, input logic [31:0] ip);
    dec_valid_i = 1; dec_ra_i = ra; dec_rb_i = rb; dec_rc_i = 0; dec_rt_i = rt;
    dec_rfwr_i = rfwr; dec_needrc_i = 0; dec_ui_i = 0; dec_ip_i = ip;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic run_vec(input vec_t v, input int i);
    dec_valid_i = v.dv; dec_ra_i = v.ra; dec_rb_i = v.rb; dec_rc_i = v.rc;
    dec_rt_i = v.rt; dec_rfwr_i = v.rfwr; dec_needrc_i = v.nrc; dec_ui_i = v.ui;
    dec_ip_i = v.ip; iss_ready_i = v.irdy; wb_valid_i = v.wbv; wb_rt_i = v.wbrt;
    flush_i = v.fl;
    #1;
    check($sformatf("v%0d_dec_ready", i), 32'(dec_ready_o), 32'(v.e_rdy));
    check($sformatf("v%0d_rf_ra", i), 32'(rf_ra_o), 32'(v.e_ra));
    check($sformatf("v%0d_rf_rb", i), 32'(rf_rb_o), 32'(v.e_rb));
    check($sformatf("v%0d_iss_valid", i), 32'(iss_valid_o), 32'(v.e_iv));
    check($sformatf("v%0d_uiexc", i), 32'(uiexc_o), 32'(v.e_ui));
    check($sformatf("v%0d_stall_cnt", i), 32'(stall_cnt_o), 32'(v.e_stall));
    check($sformatf("v%0d_busy[%0d]", i, v.bit_idx), 32'(dut.busy_q[v.bit_idx]), 32'(v.e_bit));
    if (v.e_iv) begin
      check($sformatf("v%0d_iss_rt", i), 32'(iss_rt_o), 32'(v.e_rt));
      check($sformatf("v%0d_iss_ip", i), iss_ip_o, v.e_ip);
    end
    if (v.e_ui) check($sformatf("v%0d_uiexc_ip", i), uiexc_ip_o, v.e_uiip);
    next_cycle();
  endtask

  initial begin
    //           dv ra rb rc rt wr nrc ui ip      rdy wbv wbrt fl | rdy ra rb iv rt ip      ui uiip    stall bit b
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     1, 0, 0, 0, 0, 'h0,   0, 'h0,   0,  3, 0); // reset state
    tbl[1]  = mk(1, 1, 2, 0, 3, 1, 0, 0, 'h10,   1, 0, 0, 0,     1, 0, 0, 0, 0, 'h0,   0, 'h0,   0,  3, 0); // ADD r3=r1,r2
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 1, 2, 0, 0, 'h0,   0, 'h0,   0,  3, 0); // HAZ reads 1,2
    tbl[3]  = mk(1, 3, 4, 0, 6, 1, 0, 0, 'h20,   1, 0, 0, 0,     1, 0, 0, 1, 3, 'h10,  0, 'h0,   0,  3, 0); // issue + accept reader of r3
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 3, 4, 0, 0, 'h0,   0, 'h0,   0,  3, 1); // stall
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 1, 3, 0,     0, 3, 4, 0, 0, 'h0,   0, 'h0,   1,  3, 1); // stall, wb r3
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 3, 4, 0, 0, 'h0,   0, 'h0,   2,  3, 0); // released
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 0, 0, 1, 6, 'h20,  0, 'h0,   2,  6, 0); // OUT held
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    1, 0, 0, 0,     1, 0, 0, 1, 6, 'h20,  0, 'h0,   2,  6, 0); // issue
    tbl[9]  = mk(1, 7, 8, 5, 9, 0, 1, 0, 'h30,   0, 0, 0, 0,     1, 0, 0, 0, 0, 'h0,   0, 'h0,   2,  6, 1); // store, Rc=5
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 7, 8, 0, 0, 'h0,   0, 'h0,   2,  6, 1); // HAZ
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 5, 8, 0, 0, 'h0,   0, 'h0,   2,  6, 1); // RDC
    tbl[12] = mk(1, 6, 0, 0, 0, 0, 0, 1, 'h100,  1, 0, 0, 0,     1, 0, 0, 1, 9, 'h30,  0, 'h0,   2,  9, 0); // store out, ui in
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 6, 0, 0, 0, 'h0,   1, 'h100, 2,  6, 1); // ui pulse beats hazard
    tbl[14] = mk(1, 0, 0, 0, 0, 1, 0, 0, 'h40,   0, 0, 0, 0,     1, 0, 0, 0, 0, 'h0,   0, 'h0,   2,  0, 0); // R0 writer
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 'h0,   0, 'h0,   2,  0, 0);
    tbl[16] = mk(1, 0, 0, 0, 10, 1, 0, 0, 'h50,  1, 0, 0, 0,     1, 0, 0, 1, 0, 'h40,  0, 'h0,   2,  0, 0); // issue, R0 reader
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 'h0,   0, 'h0,   2,  0, 0); // no stall on R0
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 1,     0, 0, 0, 1, 10, 'h50, 0, 'h0,   2, 10, 0); // flush in OUT
    tbl[19] = mk(1, 6, 1, 0, 11, 1, 0, 0, 'h60,  0, 0, 0, 0,     1, 0, 0, 0, 0, 'h0,   0, 'h0,   2, 10, 0); // EMPTY after flush
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 6, 1, 0, 0, 'h0,   0, 'h0,   2,  6, 1); // r6 still busy
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 'h0,    0, 0, 0, 0,     0, 6, 1, 0, 0, 'h0,   0, 'h0,   3,  6, 1);

    idle_inputs();
    rst_i = 1;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;

    for (int i = 0; i < NVEC; i++) run_vec(tbl[i], i);

    // Flush coinciding with an OUT handshake still marks the target busy,
    // and a writeback to the same register in that cycle loses to the set.
    idle_inputs();
    flush_i = 1;
    next_cycle();
    idle_inputs();
    offer(1, 1, 12, 1, 'h70);
    #1 check("seqA_accept_ready", 32'(dec_ready_o), 32'd1);
    next_cycle();
    idle_inputs();
    next_cycle();
    offer(2, 2, 13, 1, 'h74);
    iss_ready_i = 1; flush_i = 1; wb_valid_i = 1; wb_rt_i = 12;
    #1;
    check("seqA_out_valid", 32'(iss_valid_o), 32'd1);
    check("seqA_out_ip", iss_ip_o, 32'h70);
    check("seqA_flush_ready", 32'(dec_ready_o), 32'd0);
    next_cycle();
    idle_inputs();
    #1;
    check("seqA_empty_valid", 32'(iss_valid_o), 32'd0);
    check("seqA_empty_ready", 32'(dec_ready_o), 32'd1);
    check("seqA_busy12_set", 32'(dut.busy_q[12]), 32'd1);
    check("seqA_busy13_clear", 32'(dut.busy_q[13]), 32'd0);

    // Stall counter saturates: park a reader of busy r12 in HAZ.
    offer(12, 0, 14, 1, 'h80);
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 65540; c++) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("seqB_stall_sat", 32'(stall_cnt_o), 32'hFFFF);
    check("seqB_still_haz", 32'(rf_ra_o), 32'd12);
    next_cycle();
    #1 check("seqB_stall_hold", 32'(stall_cnt_o), 32'hFFFF);

    // Reset in the middle of a stall wipes everything.
    rst_i = 1;
    next_cycle();
    rst_i = 0;
    #1;
    check("seqC_ready", 32'(dec_ready_o), 32'd1);
    check("seqC_iss_valid", 32'(iss_valid_o), 32'd0);
    check("seqC_rf_ra", 32'(rf_ra_o), 32'd0);
    check("seqC_stall", 32'(stall_cnt_o), 32'd0);
    check("seqC_iss_ip", iss_ip_o, 32'd0);
    check("seqC_iss_rt", 32'(iss_rt_o), 32'd0);
    check("seqC_uiexc_ip", uiexc_ip_o, 32'd0);
    check("seqC_busy_lo", dut.busy_q[31:0], 32'd0);
    check("seqC_busy_hi", dut.busy_q[63:32], 32'd0);

    // After reset a reader of formerly-busy r12 issues without stalling.
    offer(12, 6, 15, 0, 'h90);
    next_cycle();
    idle_inputs();
    #1 check("seqC_no_stall_ra", 32'(rf_ra_o), 32'd12);
    next_cycle();
    #1;
    check("seqC_out_valid", 32'(iss_valid_o), 32'd1);
    check("seqC_out_ip", iss_ip_o, 32'h90);
    check("seqC_out_stall", 32'(stall_cnt_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
